// File: rtl/position_commit_pkg.sv
// Shared types for the move-commit engine: response codes and FSM states.
// Response code width is fixed at two bits.
package position_commit_pkg;

    localparam int RESP_CODE_W = 2;

    typedef enum logic [RESP_CODE_W-1:0] {
        RESP_ACCEPT   = 2'd0,
        RESP_OCCUPIED = 2'd1,
        RESP_OOR      = 2'd2,
        RESP_LOCKED   = 2'd3
    } resp_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/pos_onehot_decode.sv
// Index to one-hot cell decoder; indices >= N decode to all-zero.
// Latency: combinational. Backpressure: none.
module pos_onehot_decode #(
    parameter int N     = 9,
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] i_idx,
    output logic [N-1:0]     o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < N; i++) begin
            o_onehot[i] = (i_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/position_commit.sv
// Tic-tac-toe move-commit engine owning the board registers; optional undo via POSITION_COMMIT_UNDO_EN.
// Latency: handshake edge E0, response pulse in cycle 2, state visible from cycle 3.
// Backpressure: req_ready low while a request is in flight or clear is high.
module position_commit
    import position_commit_pkg::*;
#(
    parameter  int CELLS = 9,
    localparam int IDX_W = $clog2(CELLS),
    localparam int CNT_W = $clog2(CELLS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
`ifdef POSITION_COMMIT_UNDO_EN
    input  logic                   undo_req,
`endif
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [IDX_W-1:0]       req_pos,
    output logic                   resp_valid,
    output logic [RESP_CODE_W-1:0] resp_code,
    output logic [CELLS-1:0]       write_strobe,
    output logic [CELLS-1:0]       board_p1,
    output logic [CELLS-1:0]       board_p2,
    output logic                   turn,
    output logic [CNT_W-1:0]       move_count,
    output logic                   full
);

    localparam logic [IDX_W:0] LP_CELLS = (IDX_W + 1)'(CELLS);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [IDX_W-1:0]         r_pos;
    logic [RESP_CODE_W-1:0]   r_code;
    logic [CELLS-1:0]         r_strobe;
    logic [CELLS-1:0]         r_p1;
    logic [CELLS-1:0]         r_p2;
    logic                     r_turn;
    logic [CNT_W-1:0]         r_count;

    logic [CELLS-1:0]         w_onehot;
    resp_code_t               w_code;
    logic [CELLS-1:0]         w_strobe;
    logic                     w_start;
    logic                     w_full;
    logic                     w_undo;
    logic [CELLS-1:0]         w_last;
    logic                     w_last_vld;

    pos_onehot_decode #(.N(CELLS), .IDX_W(IDX_W)) u_decode (
        .i_idx    (r_pos),
        .o_onehot (w_onehot)
    );

`ifdef POSITION_COMMIT_UNDO_EN
    logic             r_is_undo;
    logic [CELLS-1:0] r_last;
    logic             r_last_vld;

    // Undo wins over a move request in IDLE, so the move is held off.
    assign req_ready  = (r_state == ST_IDLE) & ~clear & ~undo_req;
    assign w_start    = (r_state == ST_IDLE) & ~clear & (undo_req | req_valid);
    assign w_undo     = r_is_undo;
    assign w_last     = r_last;
    assign w_last_vld = r_last_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_undo  <= 1'b0;
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else if (clear) begin
            r_is_undo  <= 1'b0;
            r_last_vld <= 1'b0;
        end else if (w_start) begin
            r_is_undo  <= undo_req;
        end else if (r_state == ST_RESP && r_code == RESP_ACCEPT) begin
            r_last     <= r_strobe;
            r_last_vld <= ~r_is_undo;
        end
    end
`else
    assign req_ready  = (r_state == ST_IDLE) & ~clear;
    assign w_start    = req_ready & req_valid;
    assign w_undo     = 1'b0;
    assign w_last     = '0;
    assign w_last_vld = 1'b0;
`endif

    assign w_full = (r_count == CNT_W'(CELLS));

    always_comb begin
        w_next_state = r_state;
        resp_valid   = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_start) w_next_state = ST_CHECK;
            ST_CHECK: w_next_state = ST_RESP;
            ST_RESP: begin
                w_next_state = ST_IDLE;
                resp_valid   = ~clear;
            end
            default:  w_next_state = ST_IDLE;
        endcase
        if (clear) w_next_state = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_code   = RESP_ACCEPT;
        w_strobe = w_onehot;
        if ({1'b0, r_pos} >= LP_CELLS)      w_code = RESP_OOR;
        else if (w_full)                    w_code = RESP_LOCKED;
        else if (|((r_p1 | r_p2) & w_onehot)) w_code = RESP_OCCUPIED;
        if (w_undo) begin
            w_strobe = w_last;
            w_code   = w_last_vld ? RESP_ACCEPT : RESP_LOCKED;
        end
        if (w_code != RESP_ACCEPT) w_strobe = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos    <= '0;
            r_code   <= '0;
            r_strobe <= '0;
            r_p1     <= '0;
            r_p2     <= '0;
            r_turn   <= 1'b0;
            r_count  <= '0;
        end else if (clear) begin
            r_p1     <= '0;
            r_p2     <= '0;
            r_turn   <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_start) r_pos <= req_pos;
                ST_CHECK: begin
                    r_code   <= w_code;
                    r_strobe <= w_strobe;
                end
                ST_RESP: if (r_code == RESP_ACCEPT) begin
                    r_turn <= ~r_turn;
                    if (w_undo) begin
                        r_p1    <= r_p1 & ~r_strobe;
                        r_p2    <= r_p2 & ~r_strobe;
                        r_count <= r_count - CNT_W'(1);
                    end else begin
                        if (r_turn) r_p2 <= r_p2 | r_strobe;
                        else        r_p1 <= r_p1 | r_strobe;
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_code    = r_code;
    assign write_strobe = resp_valid ? r_strobe : '0;
    assign board_p1     = r_p1;
    assign board_p2     = r_p2;
    assign turn         = r_turn;
    assign move_count   = r_count;
    assign full         = w_full;

endmodule

// File: tb/tb_position_commit.sv
// Scoreboard bench for position_commit at CELLS=9 and CELLS=16; undo cases need POSITION_COMMIT_UNDO_EN.
module tb_position_commit;
    import position_commit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        undo_req = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_pos = '0;
    logic        req_ready, resp_valid, turn, full;
    logic [1:0]  resp_code;
    logic [8:0]  write_strobe, board_p1, board_p2;
    logic [3:0]  move_count;

    logic        b_req_valid = 1'b0;
    logic [3:0]  b_req_pos = '0;
    logic        b_req_ready, b_resp_valid, b_turn, b_full;
    logic [1:0]  b_resp_code;
    logic [15:0] b_write_strobe, b_board_p1, b_board_p2;
    logic [4:0]  b_move_count;

    position_commit #(.CELLS(9)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
`ifdef POSITION_COMMIT_UNDO_EN
        .undo_req(undo_req),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_pos(req_pos),
        .resp_valid(resp_valid), .resp_code(resp_code), .write_strobe(write_strobe),
        .board_p1(board_p1), .board_p2(board_p2), .turn(turn),
        .move_count(move_count), .full(full)
    );

    position_commit #(.CELLS(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
`ifdef POSITION_COMMIT_UNDO_EN
        .undo_req(1'b0),
`endif
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_pos(b_req_pos),
        .resp_valid(b_resp_valid), .resp_code(b_resp_code), .write_strobe(b_write_strobe),
        .board_p1(b_board_p1), .board_p2(b_board_p2), .turn(b_turn),
        .move_count(b_move_count), .full(b_full)
    );

    typedef struct packed {
        logic [1:0]  code;
        logic [15:0] strobe;
    } exp_t;

    exp_t q9[$];
    exp_t q16[$];
    exp_t e9, e16;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            total++;
            if (q9.size() == 0) begin
                bad++;
                $display("FAIL resp9_unexpected: got code %0d strobe %0h expected no response", resp_code, write_strobe);
            end else begin
                e9 = q9.pop_front();
                if (resp_code !== e9.code || write_strobe !== e9.strobe[8:0]) begin
                    bad++;
                    $display("FAIL resp9: got code %0d strobe %0h expected code %0d strobe %0h",
                             resp_code, write_strobe, e9.code, e9.strobe[8:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b_resp_valid === 1'b1) begin
            total++;
            if (q16.size() == 0) begin
                bad++;
                $display("FAIL resp16_unexpected: got code %0d strobe %0h expected no response", b_resp_code, b_write_strobe);
            end else begin
                e16 = q16.pop_front();
                if (b_resp_code !== e16.code || b_write_strobe !== e16.strobe) begin
                    bad++;
                    $display("FAIL resp16: got code %0d strobe %0h expected code %0d strobe %0h",
                             b_resp_code, b_write_strobe, e16.code, e16.strobe);
                end
            end
        end
    end

    task automatic wait_ready9();
        int n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) check("req9_handshake_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic req9(input logic [3:0] pos, input logic [1:0] code, input logic [15:0] strobe);
        q9.push_back('{code: code, strobe: strobe});
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_pos   = pos;
        wait_ready9();
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("ready_cycle1", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("ready_cycle2", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("ready_cycle3", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic req16(input logic [3:0] pos, input logic [1:0] code, input logic [15:0] strobe);
        int n = 0;
        q16.push_back('{code: code, strobe: strobe});
        @(posedge clk); #1;
        b_req_valid = 1'b1;
        b_req_pos   = pos;
        @(negedge clk);
        while (b_req_ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) check("req16_handshake_timeout", {31'd0, b_req_ready}, 32'd1);
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_mid();
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_pos   = 4'd0;
        wait_ready9();
        @(posedge clk); #1;
        req_valid = 1'b0;
        clear     = 1'b1;
        @(negedge clk);
        check("clear_rv_cycle", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("clear_rv_after", {31'd0, resp_valid}, 32'd0);
        check("clear_ready_after", {31'd0, req_ready}, 32'd1);
        check("clear_p1", {23'd0, board_p1}, 32'h0);
        check("clear_p2", {23'd0, board_p2}, 32'h0);
        check("clear_turn", {31'd0, turn}, 32'd0);
        check("clear_count", {28'd0, move_count}, 32'd0);
    endtask

`ifdef POSITION_COMMIT_UNDO_EN
    task automatic undo9(input logic [1:0] code, input logic [15:0] strobe);
        q9.push_back('{code: code, strobe: strobe});
        @(posedge clk); #1;
        undo_req  = 1'b1;
        req_valid = 1'b1;
        req_pos   = 4'd5;
        @(negedge clk);
        check("undo_blocks_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        undo_req  = 1'b0;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_code", {30'd0, resp_code}, 32'd0);
        check("rst_strobe", {23'd0, write_strobe}, 32'd0);
        check("rst_p1", {23'd0, board_p1}, 32'd0);
        check("rst_p2", {23'd0, board_p2}, 32'd0);
        check("rst_turn", {31'd0, turn}, 32'd0);
        check("rst_count", {28'd0, move_count}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);

        req9(4'd4, RESP_ACCEPT, 16'h0010);
        check("m1_p1", {23'd0, board_p1}, 32'h010);
        check("m1_turn", {31'd0, turn}, 32'd1);
        check("m1_count", {28'd0, move_count}, 32'd1);

        req9(4'd4, RESP_OCCUPIED, 16'h0000);
        check("occ_p1", {23'd0, board_p1}, 32'h010);
        check("occ_p2", {23'd0, board_p2}, 32'h000);
        check("occ_turn", {31'd0, turn}, 32'd1);

        req9(4'd12, RESP_OOR, 16'h0000);
        check("oor_p1", {23'd0, board_p1}, 32'h010);
        check("oor_count", {28'd0, move_count}, 32'd1);

        clear_mid();

`ifdef POSITION_COMMIT_UNDO_EN
        undo9(RESP_LOCKED, 16'h0000);
        req9(4'd3, RESP_ACCEPT, 16'h0008);
        check("u_move_p1", {23'd0, board_p1}, 32'h008);
        undo9(RESP_ACCEPT, 16'h0008);
        check("u_p1", {23'd0, board_p1}, 32'h000);
        check("u_turn", {31'd0, turn}, 32'd0);
        check("u_count", {28'd0, move_count}, 32'd0);
        undo9(RESP_LOCKED, 16'h0000);
        check("u2_count", {28'd0, move_count}, 32'd0);
`endif

        for (int i = 0; i < 9; i++) begin
            s = 16'd1 << i;
            req9(4'(i), RESP_ACCEPT, s);
        end
        check("full_p1", {23'd0, board_p1}, 32'h155);
        check("full_p2", {23'd0, board_p2}, 32'h0AA);
        check("full_flag", {31'd0, full}, 32'd1);
        check("full_count", {28'd0, move_count}, 32'd9);
        check("full_turn", {31'd0, turn}, 32'd1);

        req9(4'd0, RESP_LOCKED, 16'h0000);
        req9(4'd12, RESP_OOR, 16'h0000);
        check("locked_count", {28'd0, move_count}, 32'd9);

`ifdef POSITION_COMMIT_UNDO_EN
        undo9(RESP_ACCEPT, 16'h0100);
        check("uf_p1", {23'd0, board_p1}, 32'h055);
        check("uf_full", {31'd0, full}, 32'd0);
        check("uf_turn", {31'd0, turn}, 32'd0);
`endif

        req16(4'd12, RESP_ACCEPT, 16'h1000);
        check("c16_p1", {16'd0, b_board_p1}, 32'h1000);
        check("c16_turn", {31'd0, b_turn}, 32'd1);
        req16(4'd15, RESP_ACCEPT, 16'h8000);
        check("c16_p2", {16'd0, b_board_p2}, 32'h8000);
        check("c16_count", {27'd0, b_move_count}, 32'd2);

        repeat (3) @(negedge clk);
        check("q9_drained", q9.size(), 32'd0);
        check("q16_drained", q16.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
